// File: rtl/rs_age_wakeup.sv
// Reservation station with multi-channel CDB wakeup, issue-cycle bypass and
// oldest-ready-first selection behind a valid/ready dispatch handshake.
module rs_age_wakeup #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned ROB_BIT  = 4,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       issue_valid_in,
  input  logic [6:0]                 issue_op_type_in,
  input  logic [2:0]                 issue_op_in,
  input  logic                       issue_funct7b5_in,
  input  logic [XLEN-1:0]            issue_v1_in,
  input  logic [XLEN-1:0]            issue_v2_in,
  input  logic                       issue_dep1_in,
  input  logic                       issue_dep2_in,
  input  logic [ROB_BIT-1:0]         issue_q1_in,
  input  logic [ROB_BIT-1:0]         issue_q2_in,
  input  logic [ROB_BIT-1:0]         issue_rd_rob_in,
  input  logic [XLEN-1:0]            issue_pc_in,
  input  logic [NUM_CDB-1:0]         cdb_valid_in,
  input  logic [NUM_CDB*ROB_BIT-1:0] cdb_rob_in,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value_in,
  output logic                       disp_valid_out,
  input  logic                       disp_ready_in,
  output logic [6:0]                 disp_op_type_out,
  output logic [2:0]                 disp_op_out,
  output logic                       disp_funct7b5_out,
  output logic [XLEN-1:0]            disp_v1_out,
  output logic [XLEN-1:0]            disp_v2_out,
  output logic [ROB_BIT-1:0]         disp_rd_rob_out,
  output logic [XLEN-1:0]            disp_pc_out,
  output logic                       full_out,
  output logic [$clog2(RS_DEPTH):0]  count_out
);

  localparam int unsigned RS_BIT = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W  = RS_BIT + 1;

  typedef struct packed {
    logic [6:0]         op_type;
    logic [2:0]         op;
    logic               funct7b5;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
    logic               dep1;
    logic               dep2;
    logic [ROB_BIT-1:0] q1;
    logic [ROB_BIT-1:0] q2;
    logic [ROB_BIT-1:0] rd_rob;
    logic [XLEN-1:0]    pc;
    logic [RS_BIT-1:0]  age;
  } entry_t;

  entry_t             ent_q [RS_DEPTH];
  entry_t             ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [RS_DEPTH-1:0] ready;
  logic               sel_found;
  logic [RS_BIT-1:0]  sel_idx;
  logic [RS_BIT-1:0]  sel_age;
  logic [RS_BIT-1:0]  free_idx;
  logic               issue_acc;
  logic               fire;
  entry_t             sel_ent;
  entry_t             new_ent;

  // True when any valid channel broadcasts the given tag.
  function automatic logic cdb_hit(input logic [ROB_BIT-1:0] tag,
                                   input logic [NUM_CDB-1:0] vld,
                                   input logic [NUM_CDB*ROB_BIT-1:0] rob);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      if (vld[k] && (rob[k*ROB_BIT +: ROB_BIT] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Value of the lowest-numbered matching channel (scanned high to low).
  function automatic logic [XLEN-1:0] cdb_val(input logic [ROB_BIT-1:0] tag,
                                              input logic [NUM_CDB-1:0] vld,
                                              input logic [NUM_CDB*ROB_BIT-1:0] rob,
                                              input logic [NUM_CDB*XLEN-1:0] val);
    logic [XLEN-1:0] res;
    res = '0;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (vld[k] && (rob[k*ROB_BIT +: ROB_BIT] == tag)) res = val[k*XLEN +: XLEN];
    end
    return res;
  endfunction

  // Readiness uses registered state only; same-cycle wakeups dispatch next cycle.
  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ready[i] = busy_q[i] && !ent_q[i].dep1 && !ent_q[i].dep2;
    end
  end

  // Oldest ready entry: largest age wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (ready[i] && (!sel_found || (ent_q[i].age > sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = RS_BIT'(i);
        sel_age   = ent_q[i].age;
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = RS_BIT'(i);
    end
  end

  assign full_out       = &busy_q;
  assign count_out      = count_q;
  assign issue_acc      = issue_valid_in && !full_out;
  assign disp_valid_out = sel_found && rdy_in;
  assign fire           = disp_valid_out && disp_ready_in;
  assign sel_ent        = ent_q[sel_idx];

  assign disp_op_type_out  = sel_found ? sel_ent.op_type  : '0;
  assign disp_op_out       = sel_found ? sel_ent.op       : '0;
  assign disp_funct7b5_out = sel_found ? sel_ent.funct7b5 : 1'b0;
  assign disp_v1_out       = sel_found ? sel_ent.v1       : '0;
  assign disp_v2_out       = sel_found ? sel_ent.v2       : '0;
  assign disp_rd_rob_out   = sel_found ? sel_ent.rd_rob   : '0;
  assign disp_pc_out       = sel_found ? sel_ent.pc       : '0;

  // Incoming op with the issue-cycle CDB bypass applied.
  always_comb begin
    new_ent          = '0;
    new_ent.op_type  = issue_op_type_in;
    new_ent.op       = issue_op_in;
    new_ent.funct7b5 = issue_funct7b5_in;
    new_ent.q1       = issue_q1_in;
    new_ent.q2       = issue_q2_in;
    new_ent.rd_rob   = issue_rd_rob_in;
    new_ent.pc       = issue_pc_in;
    new_ent.v1       = issue_v1_in;
    new_ent.v2       = issue_v2_in;
    new_ent.dep1     = issue_dep1_in;
    new_ent.dep2     = issue_dep2_in;
    if (issue_dep1_in && cdb_hit(issue_q1_in, cdb_valid_in, cdb_rob_in)) begin
      new_ent.dep1 = 1'b0;
      new_ent.v1   = cdb_val(issue_q1_in, cdb_valid_in, cdb_rob_in, cdb_value_in);
    end
    if (issue_dep2_in && cdb_hit(issue_q2_in, cdb_valid_in, cdb_rob_in)) begin
      new_ent.dep2 = 1'b0;
      new_ent.v2   = cdb_val(issue_q2_in, cdb_valid_in, cdb_rob_in, cdb_value_in);
    end
  end

  // Next state: flush beats wakeup, dispatch and issue; rdy_in low holds everything.
  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) ent_d[i] = ent_q[i];
    busy_d  = busy_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        busy_d  = '0;
        count_d = '0;
      end else begin
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
          if (busy_q[i]) begin
            if (ent_q[i].dep1 && cdb_hit(ent_q[i].q1, cdb_valid_in, cdb_rob_in)) begin
              ent_d[i].dep1 = 1'b0;
              ent_d[i].v1   = cdb_val(ent_q[i].q1, cdb_valid_in, cdb_rob_in, cdb_value_in);
            end
            if (ent_q[i].dep2 && cdb_hit(ent_q[i].q2, cdb_valid_in, cdb_rob_in)) begin
              ent_d[i].dep2 = 1'b0;
              ent_d[i].v2   = cdb_val(ent_q[i].q2, cdb_valid_in, cdb_rob_in, cdb_value_in);
            end
            if (issue_acc && !(fire && (sel_idx == RS_BIT'(i)))) begin
              ent_d[i].age = ent_q[i].age + RS_BIT'(1);
            end
          end
        end
        if (fire) busy_d[sel_idx] = 1'b0;
        if (issue_acc) begin
          ent_d[free_idx]  = new_ent;
          busy_d[free_idx] = 1'b1;
        end
        count_d = count_q + CNT_W'(issue_acc) - CNT_W'(fire);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_age_wakeup.sv
// Directed bench for rs_age_wakeup: per-cycle vector table plus hand-written
// fill/drop and asynchronous reset sequences.
module tb_rs_age_wakeup;

  logic        clk, rst, rdy, flush;
  logic        iv, d1, d2, f7;
  logic [6:0]  op_type;
  logic [2:0]  op;
  logic [31:0] v1, v2, pc;
  logic [3:0]  q1, q2, rd;
  logic [1:0]  cv;
  logic [7:0]  crob;
  logic [63:0] cval;
  logic        dvalid, dready, full;
  logic [6:0]  dop_type;
  logic [2:0]  dop;
  logic        df7;
  logic [31:0] dv1, dv2, dpc;
  logic [3:0]  drd, cnt;

  int n_checks = 0;
  int n_fail   = 0;

  rs_age_wakeup dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .issue_valid_in(iv), .issue_op_type_in(op_type), .issue_op_in(op),
    .issue_funct7b5_in(f7), .issue_v1_in(v1), .issue_v2_in(v2),
    .issue_dep1_in(d1), .issue_dep2_in(d2), .issue_q1_in(q1), .issue_q2_in(q2),
    .issue_rd_rob_in(rd), .issue_pc_in(pc),
    .cdb_valid_in(cv), .cdb_rob_in(crob), .cdb_value_in(cval),
    .disp_valid_out(dvalid), .disp_ready_in(dready),
    .disp_op_type_out(dop_type), .disp_op_out(dop), .disp_funct7b5_out(df7),
    .disp_v1_out(dv1), .disp_v2_out(dv2), .disp_rd_rob_out(drd), .disp_pc_out(dpc),
    .full_out(full), .count_out(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv; logic d1; logic [3:0] q1; logic [31:0] v1;
    logic        d2; logic [3:0] q2; logic [31:0] v2; logic [3:0] rd;
    logic [1:0]  cv; logic [7:0] crob; logic [63:0] cval;
    logic        dr; logic rdy; logic fl;
    logic        e_valid; logic [3:0] e_rd; logic [31:0] e_v1; logic [31:0] e_v2;
    logic [3:0]  e_cnt; logic e_full;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iv = 1'b0; d1 = 1'b0; d2 = 1'b0; q1 = '0; q2 = '0; v1 = '0; v2 = '0; rd = '0;
    cv = '0; crob = '0; cval = '0; dready = 1'b0; rdy = 1'b1; flush = 1'b0;
    op_type = 7'h33; op = 3'b000; f7 = 1'b0; pc = '0;
  endtask

  // Drive one vector mid-cycle and check outputs before the next rising edge.
  task automatic apply_vec(input vec_t t, input int idx);
    @(negedge clk);
    iv = t.iv; d1 = t.d1; q1 = t.q1; v1 = t.v1; d2 = t.d2; q2 = t.q2; v2 = t.v2;
    rd = t.rd; pc = {26'd0, t.rd, 2'b00};
    cv = t.cv; crob = t.crob; cval = t.cval; dready = t.dr; rdy = t.rdy; flush = t.fl;
    #1;
    chk($sformatf("v%0d.valid", idx), 32'(dvalid), 32'(t.e_valid));
    chk($sformatf("v%0d.rd", idx),    32'(drd),    32'(t.e_rd));
    chk($sformatf("v%0d.v1", idx),    dv1,         t.e_v1);
    chk($sformatf("v%0d.v2", idx),    dv2,         t.e_v2);
    chk($sformatf("v%0d.count", idx), 32'(cnt),    32'(t.e_cnt));
    chk($sformatf("v%0d.full", idx),  32'(full),   32'(t.e_full));
  endtask

  initial begin
    //          iv d1 q1 v1          d2 q2 v2        rd  cv     crob   cval                    dr rdy fl  ev rd v1          v2        cnt full
    tbl[0]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[1]  = '{1, 0, 0, 32'h0A,     0, 0, 32'hA2,   1,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[2]  = '{1, 0, 0, 32'h0B,     0, 0, 32'hB2,   2,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  1, 1, 32'h0A,     32'hA2,   1, 0};
    tbl[3]  = '{1, 0, 0, 32'h0C,     0, 0, 32'hC2,   3,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  1, 1, 32'h0A,     32'hA2,   2, 0};
    tbl[4]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 1, 32'h0A,     32'hA2,   3, 0};
    tbl[5]  = '{1, 0, 0, 32'h0D,     0, 0, 32'hD2,   4,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  1, 2, 32'h0B,     32'hB2,   2, 0};
    tbl[6]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 2, 32'h0B,     32'hB2,   3, 0};
    tbl[7]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 3, 32'h0C,     32'hC2,   2, 0};
    tbl[8]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 4, 32'h0D,     32'hD2,   1, 0};
    tbl[9]  = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[10] = '{1, 1, 3, 32'h0,      1, 5, 32'h0,    5,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[11] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b11, 8'h53, 64'h00000022_00000011,  0, 1, 0,  0, 0, 32'h0,      32'h0,    1, 0};
    tbl[12] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 5, 32'h11,     32'h22,   1, 0};
    tbl[13] = '{1, 1, 3, 32'h0,      0, 0, 32'h66,   6,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[14] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b11, 8'h33, 64'h00000099_00000077,  0, 1, 0,  0, 0, 32'h0,      32'h0,    1, 0};
    tbl[15] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 6, 32'h77,     32'h66,   1, 0};
    tbl[16] = '{1, 1, 7, 32'h0,      0, 0, 32'h5,    7,  2'b10, 8'h70, 64'h0000DEAD_00000000,  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[17] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 7, 32'hDEAD,   32'h5,    1, 0};
    tbl[18] = '{1, 1, 9, 32'h0,      0, 0, 32'h1,    8,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[19] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b01, 8'h09, 64'h00000000_00001234,  1, 0, 0,  0, 0, 32'h0,      32'h0,    1, 0};
    tbl[20] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    1, 0};
    tbl[21] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b01, 8'h09, 64'h00000000_00004321,  0, 1, 0,  0, 0, 32'h0,      32'h0,    1, 0};
    tbl[22] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 0, 0,  0, 8, 32'h4321,   32'h1,    1, 0};
    tbl[23] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  1, 8, 32'h4321,   32'h1,    1, 0};
    tbl[24] = '{1, 0, 0, 32'h9,      0, 0, 32'h0,    9,  2'b00, 8'h00, 64'h0,                  0, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};
    tbl[25] = '{1, 0, 0, 32'h10,     0, 0, 32'h0,    10, 2'b00, 8'h00, 64'h0,                  1, 1, 1,  1, 9, 32'h9,      32'h0,    1, 0};
    tbl[26] = '{0, 0, 0, 32'h0,      0, 0, 32'h0,    0,  2'b00, 8'h00, 64'h0,                  1, 1, 0,  0, 0, 32'h0,      32'h0,    0, 0};

    idle_inputs();
    rst = 1'b1;
    #2;
    chk("reset.valid", 32'(dvalid), 32'd0);
    chk("reset.count", 32'(cnt), 32'd0);
    chk("reset.full",  32'(full), 32'd0);
    chk("reset.v1",    dv1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) apply_vec(tbl[i], i);

    // Fill every slot, then an issue alongside a dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_inputs();
      iv = 1'b1; rd = 4'(i + 1); v1 = 32'(i + 1);
      #1;
      chk($sformatf("fill%0d.count", i), 32'(cnt), 32'(i));
    end
    @(negedge clk);
    idle_inputs();
    iv = 1'b1; rd = 4'd15; v1 = 32'hFF; dready = 1'b1;
    #1;
    chk("full.full",  32'(full), 32'd1);
    chk("full.count", 32'(cnt), 32'd8);
    chk("full.rd",    32'(drd), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drop.count", 32'(cnt), 32'd7);
    chk("drop.full",  32'(full), 32'd0);
    chk("drop.rd",    32'(drd), 32'd2);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      dready = 1'b1;
      #1;
      chk($sformatf("drain%0d.rd", j),    32'(drd), 32'(j + 2));
      chk($sformatf("drain%0d.count", j), 32'(cnt), 32'(7 - j));
    end

    // Asynchronous reset between edges with entries still held.
    @(negedge clk);
    dready = 1'b0;
    #1;
    chk("pre_rst.count", 32'(cnt), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.valid", 32'(dvalid), 32'd0);
    chk("async_rst.count", 32'(cnt), 32'd0);
    chk("async_rst.full",  32'(full), 32'd0);
    chk("async_rst.rd",    32'(drd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.count", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
